// File: rtl/apb2axi_shim_if.sv
// Bus bundle for apb2axi_shim: APB3/4 slave side and AXI4-Lite master side.
// The bridge takes the apb_slave and axi_master views; the surrounding system
// (or a bench) drives the apb_master and axi_slave views of the same instance.
interface apb2axi_shim_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // APB
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [STRB_WIDTH-1:0]     PSTRB;
    logic [2:0]                PPROT;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    // AXI4-Lite
    logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [2:0]                m_axi_awprot;
    logic                      m_axi_awvalid;
    logic                      m_axi_awready;
    logic [DATA_WIDTH-1:0]     m_axi_wdata;
    logic [STRB_WIDTH-1:0]     m_axi_wstrb;
    logic                      m_axi_wvalid;
    logic                      m_axi_wready;
    logic [1:0]                m_axi_bresp;
    logic                      m_axi_bvalid;
    logic                      m_axi_bready;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [2:0]                m_axi_arprot;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [DATA_WIDTH-1:0]     m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    modport apb_slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );

    modport apb_master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport axi_master (
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport axi_slave (
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/apb2axi_shim.sv
// apb2axi_shim: APB slave to AXI4-Lite master bridge. Every APB transfer is
// turned into one single-beat AXI4-Lite read or write; PREADY is held low
// until the AXI response has been consumed.
// Optional feature macro: APB2AXI_TIMEOUT_EN -- adds a response timeout that
// completes the APB transfer with PSLVERR after TIMEOUT_CYCLES and drains the
// late AXI response in the DRAIN state.
module apb2axi_shim #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               aclk,
    input  logic               aresetn,
    apb2axi_shim_if.apb_slave  apb,
    apb2axi_shim_if.axi_master axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (AXI_ADDR_WIDTH < APB_ADDR_WIDTH || DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb2axi_shim: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
`ifdef APB2AXI_TIMEOUT_EN
        , S_DRAIN
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic [2:0]                prot_q, prot_d;
    logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      err_q, err_d;

`ifdef APB2AXI_TIMEOUT_EN
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      drain_q, drain_d;   // a timed-out response is still owed
    logic                      is_wr_q, is_wr_d;   // direction of the owed response
    logic                      resume_q, resume_d; // just left DRAIN: accept a held access phase
`endif

    logic start;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic pready, pslverr;

    // State and captured-request registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            prot_q    <= '0;
            prdata_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef APB2AXI_TIMEOUT_EN
            cnt_q     <= '0;
            drain_q   <= 1'b0;
            is_wr_q   <= 1'b0;
            resume_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge
            // value of its neighbours, independent of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            prot_q    <= prot_d;
            prdata_q  <= prdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
`ifdef APB2AXI_TIMEOUT_EN
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            is_wr_q   <= is_wr_d;
            resume_q  <= resume_d;
`endif
        end
    end

    // Next-state logic and all handshake outputs, decoded from the state.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned (which would infer a latch).
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        prot_d    = prot_q;
        prdata_d  = prdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        start     = apb.PSEL && !apb.PENABLE;
`ifdef APB2AXI_TIMEOUT_EN
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        is_wr_d   = is_wr_q;
        resume_d  = resume_q;
        // A setup issued while draining has already moved to its access phase.
        start     = apb.PSEL && (!apb.PENABLE || resume_q);
`endif

        case (state_q)
            S_IDLE: begin
`ifdef APB2AXI_TIMEOUT_EN
                resume_d = 1'b0;
                if (start) is_wr_d = apb.PWRITE;
`endif
                if (start) begin
                    addr_d    = AXI_ADDR_WIDTH'(apb.PADDR);
                    wdata_d   = apb.PWDATA;
                    wstrb_d   = apb.PSTRB;
                    prot_d    = apb.PPROT;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = apb.PWRITE ? S_WR_REQ : S_RD_REQ;
                end
            end

            S_WR_REQ: begin
                // AW and W retire independently; leave once both have.
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && axi.m_axi_awready) aw_done_d = 1'b1;
                if (wvalid && axi.m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)        state_d   = S_WR_RESP;
`ifdef APB2AXI_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            S_WR_RESP: begin
                bready = 1'b1;
                if (axi.m_axi_bvalid) begin
                    err_d   = axi.m_axi_bresp[1];
                    state_d = S_DONE;
                end
`ifdef APB2AXI_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            S_RD_REQ: begin
                arvalid = 1'b1;
                if (axi.m_axi_arready) state_d = S_RD_RESP;
`ifdef APB2AXI_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            S_RD_RESP: begin
                rready = 1'b1;
                if (axi.m_axi_rvalid) begin
                    prdata_d = axi.m_axi_rdata;
                    err_d    = axi.m_axi_rresp[1];
                    state_d  = S_DONE;
                end
`ifdef APB2AXI_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    prdata_d = '0;
                    err_d    = 1'b1;
                    drain_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            S_DONE: begin
                pready  = 1'b1;
                pslverr = err_q;
                state_d = S_IDLE;
`ifdef APB2AXI_TIMEOUT_EN
                // Keep accepting the late response even during the error pulse.
                if (drain_q) begin
                    bready = is_wr_q;
                    rready = !is_wr_q;
                    if (is_wr_q ? axi.m_axi_bvalid : axi.m_axi_rvalid) begin
                        drain_d  = 1'b0;
                        resume_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
`endif
            end

`ifdef APB2AXI_TIMEOUT_EN
            S_DRAIN: begin
                bready = is_wr_q;
                rready = !is_wr_q;
                if (is_wr_q ? axi.m_axi_bvalid : axi.m_axi_rvalid) begin
                    drain_d  = 1'b0;
                    resume_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    assign apb.PRDATA        = prdata_q;
    assign apb.PREADY        = pready;
    assign apb.PSLVERR       = pslverr;

    assign axi.m_axi_awaddr  = addr_q;
    assign axi.m_axi_awprot  = prot_q;
    assign axi.m_axi_awvalid = awvalid;
    assign axi.m_axi_wdata   = wdata_q;
    assign axi.m_axi_wstrb   = wstrb_q;
    assign axi.m_axi_wvalid  = wvalid;
    assign axi.m_axi_bready  = bready;
    assign axi.m_axi_araddr  = addr_q;
    assign axi.m_axi_arprot  = prot_q;
    assign axi.m_axi_arvalid = arvalid;
    assign axi.m_axi_rready  = rready;
endmodule

// File: tb/tb_apb2axi_shim.sv
// Bench for apb2axi_shim: directed APB transfers against a delay-programmable
// AXI4-Lite slave. Stimulus pushes expected AXI requests and APB completions
// into queues; a monitor on the falling edge pops and compares them.
module tb_apb2axi_shim;
    localparam int AW = 40;
    localparam int PW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;
    localparam int WAIT_MAX = 400;

    typedef struct packed { logic [AW-1:0] addr; logic [2:0] prot; } a_exp_t;
    typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; } w_exp_t;
    typedef struct packed { logic [DW-1:0] data; logic err; } p_exp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    apb2axi_shim_if #(.AXI_ADDR_WIDTH(AW), .APB_ADDR_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    apb2axi_shim #(
        .AXI_ADDR_WIDTH(AW), .APB_ADDR_WIDTH(PW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .apb     (bus),
        .axi     (bus)
    );

    int total = 0;
    int bad = 0;
    a_exp_t aw_q[$];
    a_exp_t ar_q[$];
    w_exp_t w_q[$];
    p_exp_t apb_q[$];
    logic [DW-1:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard monitor: compares whatever the DUT presents this cycle.
    always @(negedge aclk) begin
        a_exp_t ea;
        w_exp_t ew;
        p_exp_t ep;
        if (aresetn) begin
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                if (aw_q.size() == 0) check("aw_extra", 64'(aw_q.size()), 64'd1);
                else begin
                    ea = aw_q.pop_front();
                    check("awaddr", 64'(bus.m_axi_awaddr), 64'(ea.addr));
                    check("awprot", 64'(bus.m_axi_awprot), 64'(ea.prot));
                end
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                if (w_q.size() == 0) check("w_extra", 64'(w_q.size()), 64'd1);
                else begin
                    ew = w_q.pop_front();
                    check("wdata", 64'(bus.m_axi_wdata), 64'(ew.data));
                    check("wstrb", 64'(bus.m_axi_wstrb), 64'(ew.strb));
                end
            end
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                if (ar_q.size() == 0) check("ar_extra", 64'(ar_q.size()), 64'd1);
                else begin
                    ea = ar_q.pop_front();
                    check("araddr", 64'(bus.m_axi_araddr), 64'(ea.addr));
                    check("arprot", 64'(bus.m_axi_arprot), 64'(ea.prot));
                end
            end
            if (bus.PREADY) begin
                if (apb_q.size() == 0) check("pready_extra", 64'(apb_q.size()), 64'd1);
                else begin
                    ep = apb_q.pop_front();
                    check("prdata", 64'(bus.PRDATA), 64'(ep.data));
                    check("pslverr", 64'(bus.PSLVERR), 64'(ep.err));
                end
            end
        end
    end

    // APB master: setup, access, wait for PREADY; lat = access cycles until PREADY.
    task automatic apb_xfer(input logic wr, input logic [PW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [2:0] prot, output int lat);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        bus.PSTRB   = strb;
        bus.PPROT   = prot;
        tick();
        bus.PENABLE = 1'b1;
        lat = 0;
        while (!bus.PREADY && lat < WAIT_MAX) begin
            tick();
            lat++;
        end
        if (!bus.PREADY) check("pready_wait", 64'(bus.PREADY), 64'd1);
        tick();
        check("pready_one_cycle", 64'(bus.PREADY), 64'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic aw_slave(input int dly);
        int n = 0;
        while (!bus.m_axi_awvalid && n < WAIT_MAX) begin tick(); n++; end
        if (!bus.m_axi_awvalid) check("awvalid_wait", 64'(bus.m_axi_awvalid), 64'd1);
        else begin
            repeat (dly) tick();
            bus.m_axi_awready = 1'b1;
            tick();
            bus.m_axi_awready = 1'b0;
        end
    endtask

    task automatic w_slave(input int dly);
        int n = 0;
        while (!bus.m_axi_wvalid && n < WAIT_MAX) begin tick(); n++; end
        if (!bus.m_axi_wvalid) check("wvalid_wait", 64'(bus.m_axi_wvalid), 64'd1);
        else begin
            repeat (dly) tick();
            bus.m_axi_wready = 1'b1;
            tick();
            bus.m_axi_wready = 1'b0;
        end
    endtask

    // Waits for the new request before looking at bready, so a bready left
    // high by an earlier drain is never answered by this responder.
    task automatic b_slave(input int dly, input logic [1:0] resp);
        int n = 0;
        while (!bus.m_axi_awvalid && n < WAIT_MAX) begin tick(); n++; end
        while (!bus.m_axi_bready && n < WAIT_MAX) begin tick(); n++; end
        if (!bus.m_axi_bready) check("bready_wait", 64'(bus.m_axi_bready), 64'd1);
        else begin
            repeat (dly) tick();
            bus.m_axi_bvalid = 1'b1;
            bus.m_axi_bresp  = resp;
            tick();
            bus.m_axi_bvalid = 1'b0;
            bus.m_axi_bresp  = 2'b00;
        end
    endtask

    task automatic ar_slave(input int dly);
        int n = 0;
        while (!bus.m_axi_arvalid && n < WAIT_MAX) begin tick(); n++; end
        if (!bus.m_axi_arvalid) check("arvalid_wait", 64'(bus.m_axi_arvalid), 64'd1);
        else begin
            repeat (dly) tick();
            bus.m_axi_arready = 1'b1;
            tick();
            bus.m_axi_arready = 1'b0;
        end
    endtask

    task automatic r_slave(input int dly, input logic [DW-1:0] data, input logic [1:0] resp);
        int n = 0;
        while (!bus.m_axi_arvalid && n < WAIT_MAX) begin tick(); n++; end
        while (!bus.m_axi_rready && n < WAIT_MAX) begin tick(); n++; end
        if (!bus.m_axi_rready) check("rready_wait", 64'(bus.m_axi_rready), 64'd1);
        else begin
            repeat (dly) tick();
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = data;
            bus.m_axi_rresp  = resp;
            tick();
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rresp  = 2'b00;
        end
    endtask

    task automatic wr_xfer(input logic [PW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                           input logic [2:0] prot, input int aw_d, input int w_d, input int b_d,
                           input logic [1:0] bresp, input logic exp_err, input int exp_lat);
        int lat;
        aw_q.push_back('{AW'(addr), prot});
        w_q.push_back('{data, strb});
        apb_q.push_back('{last_rdata, exp_err});
        fork
            apb_xfer(1'b1, addr, data, strb, prot, lat);
            aw_slave(aw_d);
            w_slave(w_d);
            b_slave(b_d, bresp);
        join
        check("wr_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic rd_xfer(input logic [PW-1:0] addr, input logic [2:0] prot, input int ar_d, input int r_d,
                           input logic [DW-1:0] rdata, input logic [1:0] rresp, input logic exp_err,
                           input int exp_lat);
        int lat;
        ar_q.push_back('{AW'(addr), prot});
        apb_q.push_back('{rdata, exp_err});
        fork
            apb_xfer(1'b0, addr, '0, '0, prot, lat);
            ar_slave(ar_d);
            r_slave(r_d, rdata, rresp);
        join
        last_rdata = rdata;
        check("rd_latency", 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        int lat;
        bus.PSEL = 1'b0;          bus.PENABLE = 1'b0;       bus.PWRITE = 1'b0;
        bus.PADDR = '0;           bus.PWDATA = '0;          bus.PSTRB = '0;
        bus.PPROT = '0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
        bus.m_axi_bvalid = 1'b0;  bus.m_axi_bresp = 2'b00;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0;     bus.m_axi_rresp = 2'b00;

        repeat (3) tick();
        check("rst_pready",  64'(bus.PREADY), 64'd0);
        check("rst_pslverr", 64'(bus.PSLVERR), 64'd0);
        check("rst_prdata",  64'(bus.PRDATA), 64'd0);
        check("rst_valids",  64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid}), 64'd0);
        check("rst_readies", 64'({bus.m_axi_bready, bus.m_axi_rready}), 64'd0);
        aresetn = 1'b1;
        tick();

        // Basic write and read at minimum latency.
        wr_xfer(32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 0, 2'b00, 1'b0, 2);
        rd_xfer(32'h0000_0080, 3'd0, 0, 0, 32'h1234_5678, 2'b00, 1'b0, 2);
        // Skewed write: AW at once, W after 5, B after 3 more.
        wr_xfer(32'h0000_0044, 32'hCAFE_F00D, 4'h3, 3'b010, 0, 5, 3, 2'b00, 1'b0, 10);
        // Error responses back-to-back: SLVERR write then DECERR read.
        c0 = cyc;
        wr_xfer(32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 3'b001, 0, 0, 0, 2'b10, 1'b1, 2);
        rd_xfer(32'h0000_0104, 3'b100, 0, 0, 32'hBAD0_BAD0, 2'b11, 1'b1, 2);
        check("b2b_cycles", 64'(cyc - c0), 64'd8);
        // EXOKAY read with AR and R delays; write where W beats AW.
        rd_xfer(32'h0000_0200, 3'b011, 2, 4, 32'h0F0F_0F0F, 2'b01, 1'b0, 8);
        wr_xfer(32'hFFFF_FFFC, 32'h0102_0304, 4'h8, 3'b111, 3, 0, 0, 2'b01, 1'b0, 5);

        // Reset while waiting for R: everything drops immediately.
        ar_q.push_back('{AW'(32'h0000_0300), 3'd0});
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 32'h0000_0300; bus.PPROT = 3'd0;
        fork
            begin tick(); bus.PENABLE = 1'b1; end
            ar_slave(0);
        join
        n = 0;
        while (!bus.m_axi_rready && n < WAIT_MAX) begin tick(); n++; end
        check("rd_resp_reached", 64'(bus.m_axi_rready), 64'd1);
        aresetn = 1'b0;
        #1;
        check("midrst_ctrl", 64'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                                 bus.m_axi_arvalid, bus.m_axi_rready, bus.PREADY, bus.PSLVERR}), 64'd0);
        check("midrst_prdata", 64'(bus.PRDATA), 64'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        last_rdata = '0;
        tick();
        rd_xfer(32'h0000_0204, 3'd0, 0, 0, 32'h55AA_55AA, 2'b00, 1'b0, 2);

`ifdef APB2AXI_TIMEOUT_EN
        // B withheld: error completion after TO cycles in WR_RESP, then drain.
        aw_q.push_back('{AW'(32'h0000_0400), 3'd0});
        w_q.push_back('{32'h1111_2222, 4'hF});
        apb_q.push_back('{last_rdata, 1'b1});
        fork
            apb_xfer(1'b1, 32'h0000_0400, 32'h1111_2222, 4'hF, 3'd0, lat);
            aw_slave(0);
            w_slave(0);
        join
        check("timeout_latency", 64'(lat), 64'd17);
        check("drain_bready", 64'(bus.m_axi_bready), 64'd1);
        // Next write is held off until the late B is taken.
        aw_q.push_back('{AW'(32'h0000_0404), 3'd0});
        w_q.push_back('{32'h3333_4444, 4'hF});
        apb_q.push_back('{last_rdata, 1'b0});
        fork
            apb_xfer(1'b1, 32'h0000_0404, 32'h3333_4444, 4'hF, 3'd0, lat);
            aw_slave(0);
            w_slave(0);
            b_slave(0, 2'b00);
            begin
                for (int i = 0; i < 4; i++) begin
                    check("drain_hold_bready", 64'(bus.m_axi_bready), 64'd1);
                    check("drain_hold_aw", 64'(bus.m_axi_awvalid), 64'd0);
                    tick();
                end
                bus.m_axi_bvalid = 1'b1;
                bus.m_axi_bresp  = 2'b00;
                tick();
                bus.m_axi_bvalid = 1'b0;
            end
        join
        check("held_wr_latency", 64'(lat), 64'd7);
`endif

        repeat (3) tick();
        check("aw_q_empty",  64'(aw_q.size()), 64'd0);
        check("w_q_empty",   64'(w_q.size()), 64'd0);
        check("ar_q_empty",  64'(ar_q.size()), 64'd0);
        check("apb_q_empty", 64'(apb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
